// File: rtl/wave_gen.sv
// wave_gen: turns a 7-bit oscillator phase into an 8-bit waveform sample.
// The waveform is sine (from a quarter-wave table), square, saw or triangle.
// The pipeline has three stages and a fixed latency of three clocks.
// Waveform changes take effect only at a phase wrap, so a period is never cut.
module wave_gen #(
  parameter int SQ_AMP     = 127,
  parameter int OUT_OFFSET = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] phase,
  input  logic       phase_dv,
  input  logic [1:0] wave_sel,
  output logic [7:0] sample,
  output logic       sample_dv
);

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

  localparam logic [7:0] SQ_POS   = 8'(SQ_AMP);
  localparam logic [7:0] SQ_NEG   = 8'(-SQ_AMP);
  localparam logic [7:0] OUT_FLIP = (OUT_OFFSET != 0) ? 8'h80 : 8'h00;

  // Quarter sine, Q[i] = round(127*sin(2*pi*(i+0.5)/128)).
  function automatic logic [7:0] quarter_sine(input logic [4:0] a);
    logic [7:0] q;
    q = 8'd0;
    case (a)
      5'd0:  q = 8'd3;    5'd1:  q = 8'd9;    5'd2:  q = 8'd16;   5'd3:  q = 8'd22;
      5'd4:  q = 8'd28;   5'd5:  q = 8'd34;   5'd6:  q = 8'd40;   5'd7:  q = 8'd46;
      5'd8:  q = 8'd51;   5'd9:  q = 8'd57;   5'd10: q = 8'd63;   5'd11: q = 8'd68;
      5'd12: q = 8'd73;   5'd13: q = 8'd78;   5'd14: q = 8'd83;   5'd15: q = 8'd88;
      5'd16: q = 8'd92;   5'd17: q = 8'd96;   5'd18: q = 8'd100;  5'd19: q = 8'd104;
      5'd20: q = 8'd107;  5'd21: q = 8'd111;  5'd22: q = 8'd113;  5'd23: q = 8'd116;
      5'd24: q = 8'd118;  5'd25: q = 8'd121;  5'd26: q = 8'd122;  5'd27: q = 8'd124;
      5'd28: q = 8'd125;  5'd29: q = 8'd126;  5'd30: q = 8'd127;  5'd31: q = 8'd127;
      default: q = 8'd0;
    endcase
    return q;
  endfunction

  // Wrap tracking and the active waveform.
  wave_e      wave_act;
  logic [6:0] last_phase;
  logic       first;

  // Pipeline registers.
  logic       s1_valid, s2_valid;
  logic [6:0] s1_phase, s2_phase;
  wave_e      s1_wave, s2_wave;
  logic [4:0] s1_addr;
  logic [7:0] s2_rom;

  // Stage-0 decode: wrap detection and quarter-table address folding.
  logic       wrap;
  wave_e      wave_next;
  logic [4:0] rom_addr;
  logic [5:0] tri_t;
  logic [7:0] wave_val;

  // Pick this sample's waveform and fold the phase into the quarter table.
  always_comb begin
    // NOTE: every always_comb output is given a value up front, so no path can leave it unassigned and infer a latch.
    wrap      = 1'b0;
    wave_next = wave_act;
    rom_addr  = phase[4:0];
    wrap      = first || (phase < last_phase);
    if (wrap) wave_next = wave_e'(wave_sel);
    if (phase[5]) rom_addr = 5'd31 - phase[4:0];
  end

  // Stage-3 value for the sample held in stage 2.
  always_comb begin
    wave_val = 8'd0;
    tri_t    = s2_phase[6] ? ~s2_phase[5:0] : s2_phase[5:0];
    unique case (s2_wave)
      WAVE_SINE:   wave_val = s2_phase[6] ? (8'd0 - s2_rom) : s2_rom;
      WAVE_SQUARE: wave_val = s2_phase[6] ? SQ_NEG : SQ_POS;
      WAVE_SAW:    wave_val = {s2_phase, 1'b0} - 8'd128;
      WAVE_TRI:    wave_val = {tri_t, 2'b00} - 8'd128;
      default:     wave_val = 8'd0;
    endcase
  end

  // Control state: wrap tracker, valid bits and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      wave_act   <= WAVE_SINE;
      last_phase <= 7'd0;
      first      <= 1'b1;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      sample     <= OUT_FLIP;
      sample_dv  <= 1'b0;
    end else begin
      s1_valid  <= phase_dv;
      s2_valid  <= s1_valid;
      sample_dv <= s2_valid;
      if (phase_dv) begin
        wave_act   <= wave_next;
        last_phase <= phase;
        first      <= 1'b0;
      end
      if (s2_valid) sample <= wave_val ^ OUT_FLIP;
    end
  end

  // Datapath registers, loaded only alongside a valid bit.
  always_ff @(posedge clk) begin
    // NOTE: table data and payload registers carry no reset; the valid bits gate their use.
    if (phase_dv) begin
      s1_phase <= phase;
      s1_wave  <= wave_next;
      s1_addr  <= rom_addr;
    end
    if (s1_valid) begin
      s2_phase <= s1_phase;
      s2_wave  <= s1_wave;
      s2_rom   <= quarter_sine(s1_addr);
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Directed testbench for wave_gen: a signed-output instance and an offset-binary
// instance are driven from the same stimulus and checked against hand-computed values.
module tb_wave_gen;

  logic       clk;
  logic       rst_n;
  logic [6:0] phase;
  logic       phase_dv;
  logic [1:0] wave_sel;
  logic [7:0] sample, sample_off;
  logic       sample_dv, sample_dv_off;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  wave_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase     (phase),
    .phase_dv  (phase_dv),
    .wave_sel  (wave_sel),
    .sample    (sample),
    .sample_dv (sample_dv)
  );

  wave_gen #(.SQ_AMP(127), .OUT_OFFSET(1)) dut_off (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase     (phase),
    .phase_dv  (phase_dv),
    .wave_sel  (wave_sel),
    .sample    (sample_off),
    .sample_dv (sample_dv_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Step one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One isolated strobe; checks latency, value, offset copy and pulse width.
  task automatic one_shot(input logic [6:0] p, input logic [7:0] exp, input string tag);
    phase    = p;
    phase_dv = 1'b1;
    tick();
    phase_dv = 1'b0;
    check({tag, " dv_n1"}, {7'd0, sample_dv}, 8'd0);
    tick();
    check({tag, " dv_n2"}, {7'd0, sample_dv}, 8'd0);
    tick();
    check({tag, " dv_n3"}, {7'd0, sample_dv}, 8'd1);
    check({tag, " val"}, sample, exp);
    check({tag, " off"}, sample_off, exp ^ 8'h80);
    tick();
    check({tag, " dv_n4"}, {7'd0, sample_dv}, 8'd0);
  endtask

  logic [6:0] sin_p [8];
  logic [7:0] sin_e [8];
  int         pulses;
  int         hold_bad;
  logic [7:0] exp_v;

  initial begin
    rst_n    = 1'b0;
    phase    = 7'd0;
    phase_dv = 1'b0;
    wave_sel = 2'd0;

    // Reset held while strobes toggle: outputs stay at reset values.
    for (int i = 0; i < 6; i++) begin
      phase_dv = ~phase_dv;
      phase    = 7'(i * 9);
      tick();
      check("rst sample", sample, 8'h00);
      check("rst dv", {7'd0, sample_dv}, 8'd0);
    end
    check("rst off sample", sample_off, 8'h80);
    phase_dv = 1'b0;
    rst_n    = 1'b1;
    tick();

    // First strobe after reset: sine P=0 -> 3, three clocks later.
    one_shot(7'd0, 8'd3, "first");

    // Sine symmetry, back-to-back strobes.
    sin_p = '{7'd0, 7'd31, 7'd32, 7'd63, 7'd64, 7'd95, 7'd96, 7'd127};
    sin_e = '{8'h03, 8'h7F, 8'h7F, 8'h03, 8'hFD, 8'h81, 8'h81, 8'hFD};
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        phase    = sin_p[c];
        phase_dv = 1'b1;
      end else begin
        phase_dv = 1'b0;
      end
      tick();
      if (c >= 2 && c < 10) begin
        check("sine dv", {7'd0, sample_dv}, 8'd1);
        check("sine val", sample, sin_e[c-2]);
      end else if (c == 10) begin
        check("sine dv end", {7'd0, sample_dv}, 8'd0);
      end
    end

    // Square.
    do_reset();
    wave_sel = 2'd1;
    one_shot(7'd63, 8'h7F, "sq63");
    one_shot(7'd64, 8'h81, "sq64");

    // Saw.
    do_reset();
    wave_sel = 2'd2;
    one_shot(7'd0, 8'h80, "saw0");
    one_shot(7'd64, 8'h00, "saw64");
    one_shot(7'd127, 8'h7E, "saw127");

    // Triangle.
    do_reset();
    wave_sel = 2'd3;
    one_shot(7'd63, 8'h7C, "tri63");
    one_shot(7'd64, 8'h7C, "tri64");
    one_shot(7'd127, 8'h80, "tri127");

    // Switch requested mid-period: sine holds until the phase wraps.
    do_reset();
    wave_sel = 2'd0;
    one_shot(7'd110, 8'hA0, "sw110");
    wave_sel = 2'd1;
    one_shot(7'd115, 8'hB7, "sw115");
    one_shot(7'd120, 8'hD2, "sw120");
    one_shot(7'd125, 8'hF0, "sw125");
    one_shot(7'd2, 8'h7F, "sw2");
    one_shot(7'd7, 8'h7F, "sw7");
    // Constant phase is never a wrap, so the triangle request waits.
    wave_sel = 2'd3;
    for (int k = 0; k < 3; k++) one_shot(7'd7, 8'h7F, "hold7");
    one_shot(7'd3, 8'h8C, "wrap3");

    // Sparse strobes, one every 64 clocks.
    for (int s = 0; s < 2; s++) begin
      phase    = (s == 0) ? 7'd10 : 7'd20;
      exp_v    = (s == 0) ? 8'hA8 : 8'hD0;
      phase_dv = 1'b1;
      pulses   = 0;
      hold_bad = 0;
      for (int c = 1; c <= 64; c++) begin
        tick();
        if (c == 1) phase_dv = 1'b0;
        if (sample_dv) pulses++;
        if (c == 3) begin
          check("sparse dv", {7'd0, sample_dv}, 8'd1);
          check("sparse val", sample, exp_v);
        end
        if (c > 3 && sample !== exp_v) hold_bad++;
      end
      check("sparse pulses", 8'(pulses), 8'd1);
      check("sparse hold", 8'(hold_bad), 8'd0);
    end

    // Reset one clock after a strobe discards it.
    phase    = 7'd30;
    phase_dv = 1'b1;
    tick();
    phase_dv = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("midrst sample", sample, 8'h00);
    check("midrst dv", {7'd0, sample_dv}, 8'd0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sample_dv) pulses++;
    end
    check("midrst pulses", 8'(pulses), 8'd0);
    check("midrst hold", sample, 8'h00);
    check("midrst off", sample_off, 8'h80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
